// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode constants, FSM state enum,
// exec-counter width and an opcode classification helper.
package alu_pkg;

    // 4-bit ALU opcodes; 0xD-0xF are undefined and execute in a single cycle
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_SLT  = 4'hA;
    localparam logic [3:0] OP_SLTU = 4'hB;
    localparam logic [3:0] OP_NET  = 4'hC;

    // Width of the EXEC down-counter; covers a multi-cycle latency up to 15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // MUL and DIV are the only opcodes that take the long EXEC latency
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: searches the request vector upward from ptr with
// wrap-around and returns a one-hot grant plus the winner index.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] winner
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // First asserted request at or after ptr (modulo N_REQ) wins
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any branch, otherwise paths that skip an assignment infer latches.
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ALU arbiter: shares one combinational ALU among N_REQ requesters using a
// round-robin IDLE -> EXEC -> RESP transaction FSM.
// Optional feature: define ALU_ARBITER_DIV0_TRAP_EN to trap DIV by zero
// (one EXEC cycle, result all-ones, error flag set).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int MULDIV_LAT = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_valid_i,
    output logic [N_REQ-1:0]    req_ready_o,
    input  logic [N_REQ*32-1:0] req_data1_i,
    input  logic [N_REQ*32-1:0] req_data2_i,
    input  logic [N_REQ*4-1:0]  req_op_i,
    output logic [N_REQ-1:0]    rsp_valid_o,
    input  logic [N_REQ-1:0]    rsp_ready_i,
    output logic [31:0]         rsp_result_o,
    output logic                rsp_zero_o,
    output logic                rsp_err_o,
    output logic [31:0]         alu_data1_o,
    output logic [31:0]         alu_data2_o,
    output logic [3:0]          alu_op_o,
    input  logic [31:0]         alu_result_i,
    input  logic                alu_zero_i,
    output logic                busy_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t state_q, state_d;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] owner_q;
    logic [31:0]      data1_q, data2_q;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      result_q;
    logic             zero_q;

    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] winner;
    logic             grant_en;
    logic             capture;

    logic [31:0]      d1_arr [N_REQ];
    logic [31:0]      d2_arr [N_REQ];
    logic [3:0]       op_arr [N_REQ];
    logic [31:0]      sel_d1, sel_d2;
    logic [3:0]       sel_op;
    logic [CNT_W-1:0] sel_len;

    // Unpack the per-requester payload buses so the winner can index them
    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign d1_arr[k] = req_data1_i[k*32 +: 32];
        assign d2_arr[k] = req_data2_i[k*32 +: 32];
        assign op_arr[k] = req_op_i[k*4 +: 4];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req_valid_i),
        .ptr    (ptr_q),
        .grant  (grant),
        .winner (winner)
    );

    assign sel_d1 = d1_arr[winner];
    assign sel_d2 = d2_arr[winner];
    assign sel_op = op_arr[winner];

`ifdef ALU_ARBITER_DIV0_TRAP_EN
    logic trap_q;
    logic err_q;
    logic sel_trap;

    assign sel_trap = (sel_op == OP_DIV) && (sel_d2 == '0);
`endif

    // EXEC length minus one for the request being granted this cycle
    always_comb begin
        sel_len = is_muldiv(sel_op) ? CNT_W'(MULDIV_LAT - 1) : '0;
`ifdef ALU_ARBITER_DIV0_TRAP_EN
        if (sel_trap) begin
            sel_len = '0;
        end
`endif
    end

    // State register
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state is written with non-blocking assignments so every register samples pre-edge values, independent of block ordering.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake strobes and one-hot response valid
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        grant_en    = 1'b0;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i != '0) begin
                    req_ready_o = grant;
                    grant_en    = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o[owner_q] = 1'b1;
                if (rsp_ready_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping, operand latch, EXEC countdown and result capture
    always_ff @(posedge clk_i) begin
        // NOTE: the datapath registers are reset as well because alu_*_o and rsp_* are directly observable and must read zero after reset.
        if (rst_i) begin
            ptr_q    <= '0;
            owner_q  <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_ARBITER_DIV0_TRAP_EN
            trap_q   <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            if (grant_en) begin
                owner_q <= winner;
                ptr_q   <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
                data1_q <= sel_d1;
                data2_q <= sel_d2;
                op_q    <= sel_op;
                cnt_q   <= sel_len;
`ifdef ALU_ARBITER_DIV0_TRAP_EN
                trap_q  <= sel_trap;
`endif
            end else if ((state_q == EXEC) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (capture) begin
`ifdef ALU_ARBITER_DIV0_TRAP_EN
                if (trap_q) begin
                    result_q <= '1;
                    zero_q   <= 1'b0;
                    err_q    <= 1'b1;
                end else begin
                    result_q <= alu_result_i;
                    zero_q   <= alu_zero_i;
                    err_q    <= 1'b0;
                end
`else
                result_q <= alu_result_i;
                zero_q   <= alu_zero_i;
`endif
            end
        end
    end

    assign alu_data1_o  = data1_q;
    assign alu_data2_o  = data2_q;
    assign alu_op_o     = op_q;
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;
`ifdef ALU_ARBITER_DIV0_TRAP_EN
    assign rsp_err_o    = err_q;
`else
    assign rsp_err_o    = 1'b0;
`endif
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, with a transaction-level reference model and response scoreboard.
// Honours ALU_ARBITER_DIV0_TRAP_EN when the design is built with it.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N   = 2;
    localparam int LAT = 3;
    localparam int INF = 32'h7fff_ffff;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [N*32-1:0] req_data1_i;
    logic [N*32-1:0] req_data2_i;
    logic [N*4-1:0]  req_op_i;
    logic [N-1:0]    rsp_valid_o;
    logic [N-1:0]    rsp_ready_i;
    logic [31:0]     rsp_result_o;
    logic            rsp_zero_o;
    logic            rsp_err_o;
    logic [31:0]     alu_data1_o;
    logic [31:0]     alu_data2_o;
    logic [3:0]      alu_op_o;
    logic [31:0]     alu_result_i;
    logic            alu_zero_i;
    logic            busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .N_REQ      (N),
        .MULDIV_LAT (LAT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_data1_i  (req_data1_i),
        .req_data2_i  (req_data2_i),
        .req_op_i     (req_op_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_zero_o   (rsp_zero_o),
        .rsp_err_o    (rsp_err_o),
        .alu_data1_o  (alu_data1_o),
        .alu_data2_o  (alu_data2_o),
        .alu_op_o     (alu_op_o),
        .alu_result_i (alu_result_i),
        .alu_zero_i   (alu_zero_i),
        .busy_o       (busy_o)
    );

    // Behaviour of the shared ALU sitting outside the arbiter
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 0) ? 32'h0 : a / b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return 32'($signed(a) >>> b[4:0]);
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            OP_NET:  return {31'd0, a != b};
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result_i = alu_fn(alu_op_o, alu_data1_o, alu_data2_o);
    assign alu_zero_i   = (alu_result_i == 32'h0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          owner;
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          grant_cyc;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   ptr      = 0;
    int   free_at  = 0;
    bit   prev_rst = 1'b0;

    function automatic int rr_winner(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Builds the expected response when a request is accepted
    function automatic exp_t predict(input int w, input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input int now);
        exp_t e;
        int   len;
        len    = (op == OP_MUL || op == OP_DIV) ? LAT : 1;
        e.res  = alu_fn(op, a, b);
        e.zero = (e.res == 0);
        e.err  = 1'b0;
`ifdef ALU_ARBITER_DIV0_TRAP_EN
        if (op == OP_DIV && b == 0) begin
            len    = 1;
            e.res  = 32'hFFFF_FFFF;
            e.zero = 1'b0;
            e.err  = 1'b1;
        end
`endif
        e.owner     = w;
        e.op        = op;
        e.d1        = a;
        e.d2        = b;
        e.grant_cyc = now;
        e.due       = now + len + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        int          w;
        exp_t        e;
        logic        idle;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_valid;
        cyc++;
        if (rst_i) begin
            q.delete();
            ptr      = 0;
            free_at  = cyc + 1;
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                check("rst_result", rsp_result_o, 32'h0);
                check("rst_zero", 32'(rsp_zero_o), 32'h0);
                check("rst_err", 32'(rsp_err_o), 32'h0);
                check("rst_alu_d1", alu_data1_o, 32'h0);
                check("rst_alu_d2", alu_data2_o, 32'h0);
                check("rst_alu_op", 32'(alu_op_o), 32'h0);
            end
            prev_rst = 1'b0;

            // Request side: who should be accepted this cycle
            idle      = (cyc >= free_at);
            exp_ready = '0;
            if (idle && req_valid_i != '0) begin
                w         = rr_winner(req_valid_i, ptr);
                exp_ready = N'(1) << w;
                q.push_back(predict(w, req_op_i[w*4 +: 4], req_data1_i[w*32 +: 32],
                                    req_data2_i[w*32 +: 32], cyc));
                ptr     = (w + 1) % N;
                free_at = INF;
            end
            check("req_ready", 32'(req_ready_o), 32'(exp_ready));
            check("busy", 32'(busy_o), 32'(!idle));

            // Response side: compare whatever the DUT presents
            if (q.size() != 0) begin
                e = q[0];
                if (cyc < e.due) begin
                    if (cyc > e.grant_cyc) begin
                        check("exec_alu_op", 32'(alu_op_o), 32'(e.op));
                        check("exec_alu_d1", alu_data1_o, e.d1);
                        check("exec_alu_d2", alu_data2_o, e.d2);
                    end
                    check("rsp_valid_early", 32'(rsp_valid_o), 32'h0);
                end else begin
                    exp_valid = N'(1) << e.owner;
                    check("rsp_valid", 32'(rsp_valid_o), 32'(exp_valid));
                    check("rsp_result", rsp_result_o, e.res);
                    check("rsp_zero", 32'(rsp_zero_o), 32'(e.zero));
                    check("rsp_err", 32'(rsp_err_o), 32'(e.err));
                    if (rsp_ready_i[e.owner]) begin
                        void'(q.pop_front());
                        free_at = cyc + 1;
                    end
                end
            end else begin
                check("rsp_valid_none", 32'(rsp_valid_o), 32'h0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called just after a rising edge)
    // ------------------------------------------------------------------
    task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op_i[k*4 +: 4]     = op;
        req_data1_i[k*32 +: 32] = a;
        req_data2_i[k*32 +: 32] = b;
        req_valid_i[k]          = 1'b1;
    endtask

    task automatic wait_accept(input int k);
        bit got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (req_valid_i[k] && req_ready_o[k] && !rst_i) got = 1'b1;
        end
        check("accept_seen", 32'(got), 32'h1);
        @(posedge clk);
        #1;
        req_valid_i[k] = 1'b0;
    endtask

    task automatic issue(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        set_req(k, op, a, b);
        wait_accept(k);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy_o) break;
        end
        check("drain", 32'(q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
    endfunction

    task automatic traffic(input int cycles, input int valid_pct, input int rdy_pct, input int rst_pm);
        logic [N-1:0] hs;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            hs = req_valid_i & req_ready_o & {N{!rst_i}};
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (hs[k] || !req_valid_i[k]) begin
                    if ($urandom_range(0, 99) < valid_pct)
                        set_req(k, 4'($urandom_range(0, 15)), rand_operand(),
                                ($urandom_range(0, 3) == 0) ? 32'h0 : rand_operand());
                    else
                        req_valid_i[k] = 1'b0;
                end
                rsp_ready_i[k] = ($urandom_range(0, 99) < rdy_pct);
            end
            rst_i = ($urandom_range(0, 999) < rst_pm);
        end
        req_valid_i = '0;
        rsp_ready_i = '1;
        rst_i       = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data1_i = '0;
        req_data2_i = '0;
        req_op_i    = '0;
        rsp_ready_i = '1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // ADD 5+7 from requester 0
        issue(0, OP_ADD, 32'd5, 32'd7);
        wait_idle();

        // MUL 6*7 uses the long latency
        issue(0, OP_MUL, 32'd6, 32'd7);
        wait_idle();

        // SUB 9-9 with the response stalled; requester 0 waits meanwhile
        rsp_ready_i = '0;
        issue(1, OP_SUB, 32'd9, 32'd9);
        set_req(0, OP_ADD, 32'd1, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        rsp_ready_i = '1;
        wait_accept(0);
        wait_idle();

        // DIV by zero, trapped or executed depending on the build
        issue(0, OP_DIV, 32'd10, 32'd0);
        wait_idle();
        issue(1, OP_DIV, 32'd100, 32'd7);
        wait_idle();

        // Both requesters continuously valid: grants must alternate
        traffic(24, 100, 100, 0);
        wait_idle();

        // Reset during the EXEC phase of a MUL
        issue(0, OP_MUL, 32'd3, 32'd4);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        set_req(0, OP_ADD, 32'd2, 32'd2);
        set_req(1, OP_ADD, 32'd3, 32'd3);
        wait_accept(0);
        wait_accept(1);
        wait_idle();

        // Random traffic with back-pressure and occasional resets
        traffic(1500, 60, 70, 4);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
